// File: rtl/noc_intr_pkg.sv
// Shared definitions for the NoC interrupt bridge.
// Header layout, message constants, request FSM states.
package noc_intr_pkg;

  localparam int HDR_W      = 64;
  localparam int DST_X_LO   = 42;
  localparam int DST_X_W    = 8;
  localparam int DST_Y_LO   = 34;
  localparam int DST_Y_W    = 8;
  localparam int FBITS_LO   = 30;
  localparam int FBITS_W    = 4;
  localparam int LEN_LO     = 22;
  localparam int LEN_W      = 8;
  localparam int TYPE_LO    = 14;
  localparam int TYPE_W     = 8;

  localparam logic [TYPE_W-1:0]  MSG_TYPE_INTERRUPT = 8'd32;
  localparam logic [FBITS_W-1:0] NOC_FBITS_L1       = 4'b0000;

  typedef enum logic {
    BOOT,
    IDLE
  } req_state_t;

  function automatic logic [HDR_W-1:0] build_hdr(
    input logic [DST_X_W-1:0] x,
    input logic [DST_Y_W-1:0] y
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[DST_X_LO +: DST_X_W] = x;
    h[DST_Y_LO +: DST_Y_W] = y;
    h[FBITS_LO +: FBITS_W] = NOC_FBITS_L1;
    h[LEN_LO +: LEN_W]     = 8'd1;
    h[TYPE_LO +: TYPE_W]   = MSG_TYPE_INTERRUPT;
    return h;
  endfunction

endpackage

// File: rtl/noc_intr_rr_arb.sv
// Round-robin arbiter: search starts one past the last grant.
// Pointer moves only when a grant is actually issued.
module noc_intr_rr_arb #(
  parameter int CHANNELS = 4,
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] req,
  output logic [CHANNELS-1:0] gnt,
  output logic                vld
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  int            idx;

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sel = ptr;
    idx = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(ptr) + i) % CHANNELS;
      if (en && !vld && req[idx]) begin
        vld      = 1'b1;
        gnt[idx] = 1'b1;
        sel      = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(CHANNELS - 1);
    end else if (vld) begin
      ptr <= sel;
    end
  end

endmodule

// File: rtl/noc_intr_bridge.sv
// NoC-side interrupt bridge: inbound flit assembly, arbitrated
// interrupt requests packed into two-flit packets, output FIFO.
module noc_intr_bridge
  import noc_intr_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int IN_FLITS  = 2,
  parameter int CHANNELS  = 4,
  parameter int OUT_DEPTH = 16,
  parameter int X_TILES   = 8,
  parameter int Y_TILES   = 8,
  parameter int TILEID_W  = 32,
  parameter logic [DATA_W-1:0] BOOT_PAYLOAD = 64'h0000_0000_0001_0001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         boot_en,
  input  logic                         noc_in_val,
  output logic                         noc_in_rdy,
  input  logic [DATA_W-1:0]            noc_in_data,
  output logic                         in_pkt_val,
  input  logic                         in_pkt_rdy,
  output logic [IN_FLITS*DATA_W-1:0]   in_pkt_data,
  input  logic [CHANNELS-1:0]          intr_val,
  output logic [CHANNELS-1:0]          intr_rdy,
  input  logic [CHANNELS*TILEID_W-1:0] intr_tileid,
  input  logic [CHANNELS*DATA_W-1:0]   intr_payload,
  output logic                         noc_out_val,
  input  logic                         noc_out_rdy,
  output logic [DATA_W-1:0]            noc_out_data,
  output logic                         err_bad_tile
);

  localparam int AW    = $clog2(OUT_DEPTH);
  localparam int CW    = AW + 1;
  localparam int INW   = $clog2(IN_FLITS + 1);
  localparam int TILES = X_TILES * Y_TILES;

  // Inbound assembly
  logic [INW-1:0]             in_cnt;
  logic [IN_FLITS*DATA_W-1:0] in_buf;

  assign noc_in_rdy  = (in_cnt != INW'(IN_FLITS));
  assign in_pkt_val  = (in_cnt == INW'(IN_FLITS));
  assign in_pkt_data = in_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      in_buf <= '0;
    end else if (noc_in_val && noc_in_rdy) begin
      for (int i = 0; i < IN_FLITS; i++) begin
        if (in_cnt == INW'(i)) begin
          in_buf[(IN_FLITS-1-i)*DATA_W +: DATA_W] <= noc_in_data;
        end
      end
      in_cnt <= in_cnt + 1'b1;
    end else if (in_pkt_val && in_pkt_rdy) begin
      in_cnt <= '0;
    end
  end

  // Request path
  req_state_t          state;
  logic [CW-1:0]       count;
  logic [CW-1:0]       wr_ptr;
  logic [CW-1:0]       rd_ptr;
  logic                space;
  logic                arb_en;
  logic [CHANNELS-1:0] gnt;
  logic                any;
  logic [TILEID_W-1:0] sel_tile;
  logic [DATA_W-1:0]   sel_pay;
  logic                bad;
  logic [7:0]          dst_x;
  logic [7:0]          dst_y;
  logic                push_boot;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   hdr_flit;
  logic [DATA_W-1:0]   pay_flit;

  // Only the registered count is used: a same-cycle pop never helps.
  assign space  = (count <= CW'(OUT_DEPTH - 2));
  assign arb_en = !rst && (state == IDLE) && space;

  noc_intr_rr_arb #(
    .CHANNELS(CHANNELS)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .en (arb_en),
    .req(intr_val),
    .gnt(gnt),
    .vld(any)
  );

  assign intr_rdy = gnt;

  always_comb begin
    sel_tile = '0;
    sel_pay  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (gnt[c]) begin
        sel_tile = sel_tile | intr_tileid[c*TILEID_W +: TILEID_W];
        sel_pay  = sel_pay | intr_payload[c*DATA_W +: DATA_W];
      end
    end
  end

  assign bad   = (sel_tile >= TILEID_W'(TILES));
  assign dst_x = 8'(sel_tile % TILEID_W'(X_TILES));
  assign dst_y = 8'(sel_tile / TILEID_W'(X_TILES));

  assign push_boot = !rst && (state == BOOT) && space;
  assign push      = push_boot || (any && !bad);
  assign pop       = noc_out_val && noc_out_rdy;

  always_comb begin
    if (push_boot) begin
      hdr_flit = DATA_W'(build_hdr(8'd0, 8'd0));
      pay_flit = BOOT_PAYLOAD;
    end else begin
      hdr_flit = DATA_W'(build_hdr(dst_x, dst_y));
      pay_flit = sel_pay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= boot_en ? BOOT : IDLE;
      err_bad_tile <= 1'b0;
    end else begin
      err_bad_tile <= any && bad;
      if (state == BOOT && space) begin
        state <= IDLE;
      end
    end
  end

  // Output FIFO, dual write port so a packet is never split
  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [CW-1:0]     wr_nxt;
  logic [AW-1:0]     wr_idx0;
  logic [AW-1:0]     wr_idx1;
  logic [AW-1:0]     rd_idx;

  assign wr_nxt  = wr_ptr + 1'b1;
  assign wr_idx0 = AW'(wr_ptr % CW'(OUT_DEPTH));
  assign wr_idx1 = AW'(wr_nxt % CW'(OUT_DEPTH));
  assign rd_idx  = AW'(rd_ptr % CW'(OUT_DEPTH));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx0] <= hdr_flit;
      mem[wr_idx1] <= pay_flit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CW'(2);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'({push, 1'b0}) - CW'(pop);
    end
  end

  assign noc_out_val  = (count != '0);
  assign noc_out_data = noc_out_val ? mem[rd_idx] : '0;

endmodule
